// File: rtl/sha256_sched_ctrl_pkg.sv
// Shared constants and state encoding for the SHA-256 schedule controller.
// Used by the interface, the index counter and the controller top.
package sha256_pkg;

  localparam int BLOCK_BITS       = 512;
  localparam int WORD_BITS        = 32;
  localparam int W_LENGTH_DEFAULT = 64;
  localparam int IDX_BITS         = $clog2(W_LENGTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCHED = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } sched_state_e;

  // Plain-vector copies of the state codes for the FSM register.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SCHED = SCHED;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_CLEAR = CLEAR;

endpackage

// File: rtl/sha256_sched_ctrl_if.sv
// Block handshake, schedule controls and round-engine strobes of the controller.
// SHA256_SCHED_CTRL_PERF_EN adds the blocks_done/messages_done counters.
interface sha256_sched_ctrl_if
  import sha256_pkg::*;
#(
  parameter int W_LENGTH = W_LENGTH_DEFAULT
);

  logic                        blk_valid;
  logic                        blk_ready;
  logic [BLOCK_BITS-1:0]       blk_data;
  logic                        blk_last;
  logic                        sched_enable;
  logic [BLOCK_BITS-1:0]       sched_message;
  logic [$clog2(W_LENGTH)-1:0] sched_index;
  logic                        sched_index_complete;
  logic                        round_start;
  logic                        round_done;
  logic                        hash_init;
  logic                        digest_valid;
  logic                        busy;
`ifdef SHA256_SCHED_CTRL_PERF_EN
  logic [31:0]                 blocks_done;
  logic [15:0]                 messages_done;
`endif

  // slave: the controller itself; master: padding stage / round engine side.
  modport slave (
    input  blk_valid, blk_data, blk_last, round_done,
    output blk_ready, sched_enable, sched_message, sched_index,
           sched_index_complete, round_start, hash_init, digest_valid, busy
`ifdef SHA256_SCHED_CTRL_PERF_EN
    , output blocks_done, messages_done
`endif
  );

  modport master (
    output blk_valid, blk_data, blk_last, round_done,
    input  blk_ready, sched_enable, sched_message, sched_index,
           sched_index_complete, round_start, hash_init, digest_valid, busy
`ifdef SHA256_SCHED_CTRL_PERF_EN
    , input blocks_done, messages_done
`endif
  );

endinterface

// File: rtl/sha256_sched_ctrl_idx_cnt.sv
// Saturating schedule-word index counter with clear/enable.
// complete is registered and rises the cycle after the last index is presented.
module sha256_sched_idx_cnt #(
  parameter int W_LENGTH = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable,
  output logic [$clog2(W_LENGTH)-1:0] index,
  output logic                        complete,
  output logic                        terminal
);

  localparam int IDX_W = $clog2(W_LENGTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(W_LENGTH - 1);

  // Single-cycle strobe on the edge where complete is about to rise.
  assign terminal = enable && (index == IDX_MAX) && !complete;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index    <= '0;
      complete <= 1'b0;
    end else if (clear) begin
      index    <= '0;
      complete <= 1'b0;
    end else if (enable) begin
      if (index == IDX_MAX) begin
        complete <= 1'b1;
      end else begin
        index <= index + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_sched_ctrl.sv
// Block sequencer for the SHA-256 schedule datapath and round engine.
// Optional counters are built when SHA256_SCHED_CTRL_PERF_EN is defined.
module sha256_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int W_LENGTH = W_LENGTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  sha256_sched_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(W_LENGTH);

  logic [1:0]            state;
  logic [BLOCK_BITS-1:0] sched_message;
  logic                  first_flag;
  logic                  last_flag;
  logic                  round_start;
  logic                  hash_init;
  logic                  digest_valid;

  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  cnt_terminal;
  logic                  cnt_complete;
  logic [IDX_W-1:0]      cnt_index;

  logic                  accept;
  logic                  done_in_wait;

  assign accept       = (state == ST_IDLE) && bus.blk_valid;
  assign done_in_wait = (state == ST_WAIT) && bus.round_done;

  // Clearing on the round_done edge makes complete/index read 0 during CLEAR.
  assign cnt_clear  = (state == ST_IDLE) || (state == ST_CLEAR) || done_in_wait;
  assign cnt_enable = (state == ST_SCHED);

  sha256_sched_idx_cnt #(
    .W_LENGTH (W_LENGTH)
  ) u_idx_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .index    (cnt_index),
    .complete (cnt_complete),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sched_message <= '0;
      first_flag    <= 1'b1;
      last_flag     <= 1'b0;
      round_start   <= 1'b0;
      hash_init     <= 1'b0;
      digest_valid  <= 1'b0;
    end else begin
      round_start  <= 1'b0;
      hash_init    <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sched_message <= bus.blk_data;
            last_flag     <= bus.blk_last;
            state         <= ST_SCHED;
          end
        end
        ST_SCHED: begin
          if (cnt_terminal) begin
            round_start <= 1'b1;
            hash_init   <= first_flag;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.round_done) begin
            // The last block re-arms first_flag for the next message.
            first_flag   <= last_flag;
            digest_valid <= last_flag;
            state        <= ST_CLEAR;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.blk_ready            = (state == ST_IDLE);
  assign bus.busy                 = (state != ST_IDLE);
  assign bus.sched_enable         = (state == ST_SCHED) || (state == ST_WAIT);
  assign bus.sched_message        = sched_message;
  assign bus.sched_index          = cnt_index;
  assign bus.sched_index_complete = cnt_complete;
  assign bus.round_start          = round_start;
  assign bus.hash_init            = hash_init;
  assign bus.digest_valid         = digest_valid;

`ifdef SHA256_SCHED_CTRL_PERF_EN
  logic [31:0] blocks_done;
  logic [15:0] messages_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blocks_done   <= '0;
      messages_done <= '0;
    end else begin
      if (done_in_wait) begin
        blocks_done <= blocks_done + 32'd1;
      end
      if (digest_valid) begin
        messages_done <= messages_done + 16'd1;
      end
    end
  end

  assign bus.blocks_done   = blocks_done;
  assign bus.messages_done = messages_done;
`endif

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Scoreboard bench for sha256_sched_ctrl: stimulus pushes expected round/digest
// events, a negedge monitor pops and compares them.
module tb_sha256_sched_ctrl;
  import sha256_pkg::*;

  localparam int W = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic         hinit;
    logic [511:0] data;
    int           acc;
  } rs_t;

  rs_t rs_q[$];
  int  dv_q[$];
  rs_t mon_e;
  int  mon_d;

  // Reference model: message-level view of the block stream.
  logic model_first = 1'b1;
  int   m_blocks    = 0;
  int   m_msgs      = 0;

  sha256_sched_ctrl_if #(.W_LENGTH(W)) bus ();

  sha256_sched_ctrl #(.W_LENGTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blk_ready"}, bus.blk_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_sched_enable"}, bus.sched_enable, 0);
    chk({tag, "_sched_index"}, bus.sched_index, 0);
    chk({tag, "_complete"}, bus.sched_index_complete, 0);
    chk({tag, "_round_start"}, bus.round_start, 0);
    chk({tag, "_hash_init"}, bus.hash_init, 0);
    chk({tag, "_digest_valid"}, bus.digest_valid, 0);
    chk({tag, "_sched_message"}, bus.sched_message, 0);
`ifdef SHA256_SCHED_CTRL_PERF_EN
    chk({tag, "_blocks_done"}, bus.blocks_done, 0);
    chk({tag, "_messages_done"}, bus.messages_done, 0);
`endif
  endtask

  task automatic hard_reset();
    bus.blk_valid  = 1'b0;
    bus.round_done = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    rs_q.delete();
    dv_q.delete();
    model_first = 1'b1;
    m_blocks = 0;
    m_msgs   = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // mode: 0 normal, 1 blk_valid held with noisy data, 2 stray round_done
  // at index 20, 3 reset at index 37.
  task automatic send_block(input logic [511:0] data, input logic last,
                            input int lat, input int mode);
    int acc, k, guard;
    guard = 0;
    while (bus.blk_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      chk("blk_ready_timeout", 0, 1);
      return;
    end
    bus.blk_data  = data;
    bus.blk_last  = last;
    bus.blk_valid = 1'b1;
    @(negedge clock);
    acc = cyc;
    rs_q.push_back('{model_first, data, acc});
    chk("blk_ready_drop", bus.blk_ready, 0);
    if (mode != 1) bus.blk_valid = 1'b0;
    bus.blk_data = rnd512();
    bus.blk_last = 1'($urandom);
    k = 0;
    while (bus.round_start !== 1'b1) begin
      if (k > W + 4) begin
        chk("round_start_timeout", 0, 1);
        return;
      end
      chk("sched_index", bus.sched_index, (k < W - 1) ? k : W - 1);
      chk("complete_early", bus.sched_index_complete, 0);
      chk("sched_enable_sched", bus.sched_enable, 1);
      chk("sched_message", bus.sched_message, data);
      chk("blk_ready_sched", bus.blk_ready, 0);
      if (mode == 1) bus.blk_data = rnd512();
      if (mode == 2) bus.round_done = (k == 20);
      if (mode == 3 && k == 37) begin
        reset = 1'b1;
        bus.round_done = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        rs_q.delete();
        dv_q.delete();
        model_first = 1'b1;
        m_blocks = 0;
        m_msgs   = 0;
        @(negedge clock);
        chk("reset_mid_no_round_start", bus.round_start, 0);
        chk("reset_mid_no_digest", bus.digest_valid, 0);
        reset = 1'b0;
        @(negedge clock);
        return;
      end
      @(negedge clock);
      k++;
    end
    for (int i = 0; i < lat; i++) begin
      chk("wait_enable", bus.sched_enable, 1);
      chk("wait_complete", bus.sched_index_complete, 1);
      chk("wait_index", bus.sched_index, W - 1);
      chk("wait_message", bus.sched_message, data);
      if (mode == 1) bus.blk_data = rnd512();
      @(negedge clock);
    end
    bus.round_done = 1'b1;
    bus.blk_valid  = 1'b0;
    if (last) begin
      dv_q.push_back(cyc + 1);
      m_msgs++;
    end
    m_blocks++;
    model_first = last;
    @(negedge clock);
    bus.round_done = 1'b0;
    chk("clear_enable", bus.sched_enable, 0);
    chk("clear_complete", bus.sched_index_complete, 0);
    chk("clear_index", bus.sched_index, 0);
    chk("clear_busy", bus.busy, 1);
    @(negedge clock);
    chk("idle_busy", bus.busy, 0);
    chk("idle_ready", bus.blk_ready, 1);
  endtask

  task automatic send_msg(input int nblk, input int lat);
    for (int b = 0; b < nblk; b++)
      send_block(rnd512(), (b == nblk - 1), lat, 0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.round_start === 1'b1) begin
        if (rs_q.size() == 0) begin
          chk("unexpected_round_start", 1, 0);
        end else begin
          mon_e = rs_q.pop_front();
          chk("hash_init", bus.hash_init, mon_e.hinit);
          chk("round_message", bus.sched_message, mon_e.data);
          // Accept edge counted as cycle 1 up to the cycle showing round_start.
          chk("round_start_latency", cyc - mon_e.acc + 1, W + 1);
        end
      end else if (bus.hash_init === 1'b1) begin
        chk("hash_init_without_round_start", 1, 0);
      end
      if (bus.digest_valid === 1'b1) begin
        if (dv_q.size() == 0) begin
          chk("unexpected_digest_valid", 1, 0);
        end else begin
          mon_d = dv_q.pop_front();
          chk("digest_valid_cycle", cyc, mon_d);
        end
      end
    end
  end

  initial begin
    logic [511:0] abc;
    logic [511:0] b1;
    logic [511:0] b2;
    bus.blk_valid  = 1'b0;
    bus.blk_data   = '0;
    bus.blk_last   = 1'b0;
    bus.round_done = 1'b0;
    @(negedge clock);
    hard_reset();

    abc = {32'h61626380, 448'h0, 32'h00000018};
    send_block(abc, 1'b1, 64, 0);

    b1 = rnd512();
    b1[63:0] = {32'h80000000, 32'h0};
    b2 = {480'h0, 32'h000001c0};
    send_block(b1, 1'b0, 10, 0);
    send_block(b2, 1'b1, 10, 0);

    send_block(rnd512(), 1'b1, 5, 1);
    send_block(rnd512(), 1'b1, 7, 2);

    send_block(rnd512(), 1'b0, 3, 0);
    send_block(rnd512(), 1'b0, 3, 3);
    send_block(rnd512(), 1'b1, 4, 0);

    for (int m = 0; m < 4; m++)
      send_msg($urandom_range(1, 3), $urandom_range(1, 20));

`ifdef SHA256_SCHED_CTRL_PERF_EN
    hard_reset();
    send_msg(1, 2);
    send_msg(2, 3);
    send_msg(3, 1);
    chk("blocks_done", bus.blocks_done, m_blocks);
    chk("messages_done", bus.messages_done, m_msgs);
`endif

    repeat (3) @(negedge clock);
    chk("pending_round_start", rs_q.size(), 0);
    chk("pending_digest", dv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
